// File: rtl/frame_word_streamer_pkg.sv
// Shared types and constants for the frame word streamer.
// Optional feature macro: STREAMER_FLUSH_EN (adds the FLUSH state).
package frame_word_streamer_pkg;

    localparam int WORD_W          = 32;
    localparam int PIXELS_PER_WORD = 4;
    localparam int PIXEL_W         = WORD_W / PIXELS_PER_WORD;

    // Line-buffer depth: two edge words plus the 76-word core make one line.
    localparam int LB_EDGE_WORDS   = 2;
    localparam int LB_CORE_WORDS   = 76;
    localparam int LB_DEPTH        = LB_EDGE_WORDS + LB_CORE_WORDS;

    localparam int COL_W           = 7;
    localparam int ROW_W           = 9;
    localparam int PUSH_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_PUSH  = 3'd2,
        ST_DONE  = 3'd3
`ifdef STREAMER_FLUSH_EN
        ,
        ST_FLUSH = 3'd4
`endif
    } state_t;

    // Pushes needed before the first full 3x2 window is resident.
    function automatic int prime_threshold(input int words_per_line);
        return 2 * words_per_line + 2;
    endfunction

endpackage

// File: rtl/frame_word_streamer_raster_counter.sv
// Raster position counter: column/row of the next word to push, plus
// last-word and window-priming flags. Macro STREAMER_FLUSH_EN lets the
// row count run past the frame and adds the end-of-flush flag.
module raster_counter
    import frame_word_streamer_pkg::*;
#(
    parameter int WORDS_PER_LINE = LB_DEPTH,
    parameter int NUM_LINES      = 240
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last_word,
    output logic             prime
`ifdef STREAMER_FLUSH_EN
    ,
    output logic             flush_last
`endif
);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WORDS_PER_LINE - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(NUM_LINES - 1);
    localparam logic [PUSH_W-1:0] PRIME_AT = PUSH_W'(prime_threshold(WORDS_PER_LINE) - 1);

    logic [PUSH_W-1:0] push_cnt;

    // Advance position and push count once per pushed word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            push_cnt <= '0;
        end else if (clear) begin
            col      <= '0;
            row      <= '0;
            push_cnt <= '0;
        end else if (advance) begin
            push_cnt <= push_cnt + 1'b1;
            if (col == COL_LAST) begin
                col <= '0;
`ifdef STREAMER_FLUSH_EN
                row <= row + 1'b1;
`else
                if (row != ROW_LAST) row <= row + 1'b1;
`endif
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last_word = (col == COL_LAST) && (row == ROW_LAST);
    // The push happening now brings the count to the priming threshold.
    assign prime     = (push_cnt == PRIME_AT);

`ifdef STREAMER_FLUSH_EN
    localparam logic [PUSH_W-1:0] FLUSH_LAST_AT =
        PUSH_W'(WORDS_PER_LINE * NUM_LINES + prime_threshold(WORDS_PER_LINE) - 1);
    assign flush_last = (push_cnt == FLUSH_LAST_AT);
`endif

endmodule

// File: rtl/frame_word_streamer.sv
// Frame word streamer: reads frame words over req/ack and pushes them, one
// per REQ round trip, into the shift data path in raster order.
// Optional feature macro: STREAMER_FLUSH_EN (zero-word flush after the frame).
// Handshake: mem_req stays high with mem_addr stable until a cycle where
// mem_ack is high; that cycle's mem_rd_data is captured and mem_req drops.
module frame_word_streamer
    import frame_word_streamer_pkg::*;
#(
    parameter int WORDS_PER_LINE = LB_DEPTH,
    parameter int NUM_LINES      = 240,
    parameter int BASE_ADDR      = 0,
    parameter int ADDR_W         = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rd_data,
    output logic              write_en,
    output logic [WORD_W-1:0] data_out,
    output logic [COL_W-1:0]  word_col,
    output logic [ROW_W-1:0]  word_row,
    output logic              window_valid,
    output logic              busy,
    output logic              done,
    output state_t            state_dbg
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state;
    logic              push_now;
    logic              cnt_clear;
    logic [COL_W-1:0]  cnt_col;
    logic [ROW_W-1:0]  cnt_row;
    logic              cnt_last;
    logic              cnt_prime;
`ifdef STREAMER_FLUSH_EN
    logic              cnt_flush_last;
`endif

    // A push happens in PUSH when not held; flush pushes also leave a gap cycle.
    always_comb begin
        push_now = 1'b0;
        if (state == ST_PUSH) push_now = !hold;
`ifdef STREAMER_FLUSH_EN
        if (state == ST_FLUSH) push_now = !hold && !write_en;
`endif
    end

    assign cnt_clear = (state == ST_IDLE) && start;
    assign state_dbg = state;

    raster_counter #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .NUM_LINES      (NUM_LINES)
    ) u_raster (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clear),
        .advance    (push_now),
        .col        (cnt_col),
        .row        (cnt_row),
        .last_word  (cnt_last),
        .prime      (cnt_prime)
`ifdef STREAMER_FLUSH_EN
        ,
        .flush_last (cnt_flush_last)
`endif
    );

    // Main control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            mem_req      <= 1'b0;
            mem_addr     <= BASE;
            write_en     <= 1'b0;
            data_out     <= '0;
            word_col     <= '0;
            word_row     <= '0;
            window_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            write_en <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mem_addr     <= BASE;
                        mem_req      <= 1'b1;
                        busy         <= 1'b1;
                        window_valid <= 1'b0;
                        state        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        data_out <= mem_rd_data;
                        mem_req  <= 1'b0;
                        state    <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    if (push_now) begin
                        write_en <= 1'b1;
                        word_col <= cnt_col;
                        word_row <= cnt_row;
                        mem_addr <= mem_addr + 1'b1;
                        if (cnt_prime) window_valid <= 1'b1;
                        if (cnt_last) begin
`ifdef STREAMER_FLUSH_EN
                            state <= ST_FLUSH;
`else
                            state <= ST_DONE;
`endif
                        end else begin
                            mem_req <= 1'b1;
                            state   <= ST_REQ;
                        end
                    end
                end
`ifdef STREAMER_FLUSH_EN
                ST_FLUSH: begin
                    if (push_now) begin
                        write_en <= 1'b1;
                        data_out <= '0;
                        word_col <= cnt_col;
                        word_row <= cnt_row;
                        if (cnt_prime) window_valid <= 1'b1;
                        if (cnt_flush_last) state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    window_valid <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
